// File: rtl/mipi_cam_seq.sv
// MIPI CSI-2 camera bring-up / run-time sequencer.
// Power-up -> reset release -> register table streaming -> RX enable -> frame watchdog,
// with power-cycle retry and a sticky fault after MAX_RETRY failed attempts.
// Every timed state dwells exactly its parameter's cycle count (timer loaded with N-1),
// so cfg_valid first asserts PWR_WAIT_CYC + RST_WAIT_CYC + 1 clocks after the edge
// that samples start, and a watchdog fires exactly N clocks after its (re)load.
module mipi_cam_seq #(
  parameter int unsigned PWR_WAIT_CYC      = 500000,
  parameter int unsigned RST_WAIT_CYC      = 100000,
  parameter int unsigned NUM_REGS          = 64,
  parameter int unsigned CFG_TIMEOUT_CYC   = 50000,
  parameter int unsigned FRAME_TIMEOUT_CYC = 5000000,
  parameter int unsigned MAX_RETRY         = 3
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  output logic        sensor_pwdn,
  output logic        sensor_rst_n,
  output logic [7:0]  tbl_idx,
  input  logic [23:0] tbl_entry,
  output logic        cfg_valid,
  input  logic        cfg_ready,
  output logic [15:0] cfg_addr,
  output logic [7:0]  cfg_data,
  input  logic        cfg_done,
  input  logic        cfg_err,
  output logic        rx_enable,
  input  logic        frame_start,
  output logic        streaming,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  retry_cnt,
  output logic [2:0]  state
);

  localparam int unsigned MAX_A    = (PWR_WAIT_CYC > RST_WAIT_CYC) ? PWR_WAIT_CYC : RST_WAIT_CYC;
  localparam int unsigned MAX_B    = (CFG_TIMEOUT_CYC > FRAME_TIMEOUT_CYC) ? CFG_TIMEOUT_CYC : FRAME_TIMEOUT_CYC;
  localparam int unsigned MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned TW       = $clog2(MAX_WAIT) + 1;

  localparam logic [TW-1:0] PWR_LOAD   = TW'(PWR_WAIT_CYC - 1);
  localparam logic [TW-1:0] RST_LOAD   = TW'(RST_WAIT_CYC - 1);
  localparam logic [TW-1:0] CFG_LOAD   = TW'(CFG_TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] FRAME_LOAD = TW'(FRAME_TIMEOUT_CYC - 1);
  localparam logic [1:0]    RETRY_LAST = 2'(MAX_RETRY - 1);
  localparam logic [1:0]    RETRY_SAT  = 2'(MAX_RETRY);
  localparam logic [7:0]    IDX_END    = 8'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PWR_UP    = 3'd1,
    S_RST_REL   = 3'd2,
    S_CFG_ISSUE = 3'd3,
    S_CFG_WAIT  = 3'd4,
    S_RX_WAIT   = 3'd5,
    S_STREAM    = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  state_t        st;
  logic [TW-1:0] timer;
  logic          timer_zero;
  logic          tbl_end;
  logic          fail_evt;

  assign state = st;

  // Decode of end-of-table and the per-state failure conditions.
  always_comb begin
    timer_zero = (timer == '0);
    tbl_end    = (tbl_entry[23:8] == 16'hFFFF) || (tbl_idx == IDX_END);
    fail_evt   = 1'b0;
    case (st)
      // done+err together counts as a failure; done wins over a simultaneous timeout
      S_CFG_WAIT: fail_evt = cfg_err || (!cfg_done && timer_zero);
      S_RX_WAIT:  fail_evt = !frame_start && timer_zero;
      S_STREAM:   fail_evt = !frame_start && timer_zero;
      default:    fail_evt = 1'b0;
    endcase
  end

  // Sequencer FSM with registered outputs and the shared wait/watchdog timer.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      st           <= S_IDLE;
      sensor_pwdn  <= 1'b1;
      sensor_rst_n <= 1'b0;
      rx_enable    <= 1'b0;
      cfg_valid    <= 1'b0;
      cfg_addr     <= '0;
      cfg_data     <= '0;
      tbl_idx      <= '0;
      streaming    <= 1'b0;
      busy         <= 1'b0;
      fault        <= 1'b0;
      retry_cnt    <= '0;
      timer        <= '0;
    end else if (stop) begin
      st           <= S_IDLE;
      sensor_pwdn  <= 1'b1;
      sensor_rst_n <= 1'b0;
      rx_enable    <= 1'b0;
      cfg_valid    <= 1'b0;
      tbl_idx      <= '0;
      streaming    <= 1'b0;
      busy         <= 1'b0;
      fault        <= 1'b0;
      retry_cnt    <= '0;
      timer        <= '0;
    end else if (fail_evt) begin
      // failure: either latch the fault or power-cycle with a one-cycle pwdn pulse
      sensor_rst_n <= 1'b0;
      rx_enable    <= 1'b0;
      cfg_valid    <= 1'b0;
      tbl_idx      <= '0;
      streaming    <= 1'b0;
      sensor_pwdn  <= 1'b1;
      if (retry_cnt == RETRY_LAST) begin
        st        <= S_FAULT;
        retry_cnt <= RETRY_SAT;
        fault     <= 1'b1;
        busy      <= 1'b0;
        timer     <= '0;
      end else begin
        st        <= S_PWR_UP;
        retry_cnt <= retry_cnt + 2'd1;
        busy      <= 1'b1;
        timer     <= PWR_LOAD;
      end
    end else begin
      case (st)
        S_IDLE, S_FAULT: begin
          if (start) begin
            st           <= S_PWR_UP;
            sensor_pwdn  <= 1'b0;
            sensor_rst_n <= 1'b0;
            rx_enable    <= 1'b0;
            tbl_idx      <= '0;
            busy         <= 1'b1;
            fault        <= 1'b0;
            retry_cnt    <= '0;
            timer        <= PWR_LOAD;
          end
        end
        S_PWR_UP: begin
          sensor_pwdn <= 1'b0;
          if (timer_zero) begin
            st           <= S_RST_REL;
            sensor_rst_n <= 1'b1;
            timer        <= RST_LOAD;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_RST_REL: begin
          if (timer_zero) begin
            st      <= S_CFG_ISSUE;
            tbl_idx <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_CFG_ISSUE: begin
          if (!cfg_valid) begin
            if (tbl_end) begin
              st        <= S_RX_WAIT;
              rx_enable <= 1'b1;
              timer     <= FRAME_LOAD;
            end else begin
              cfg_addr  <= tbl_entry[23:8];
              cfg_data  <= tbl_entry[7:0];
              cfg_valid <= 1'b1;
            end
          end else if (cfg_ready) begin
            cfg_valid <= 1'b0;
            st        <= S_CFG_WAIT;
            timer     <= CFG_LOAD;
          end
        end
        S_CFG_WAIT: begin
          if (cfg_done) begin
            st      <= S_CFG_ISSUE;
            tbl_idx <= tbl_idx + 8'd1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_RX_WAIT: begin
          if (frame_start) begin
            st        <= S_STREAM;
            streaming <= 1'b1;
            busy      <= 1'b0;
            timer     <= FRAME_LOAD;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_STREAM: begin
          if (frame_start) begin
            timer <= FRAME_LOAD;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_cam_seq.sv
// Directed self-checking bench for mipi_cam_seq with a small config-engine and
// frame-source responder. Parameters shrunk: PWR=10, RST=5, CFG_TO=20, FRAME_TO=100.
module tb_mipi_cam_seq;

  logic        clk_50m = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic        stop    = 1'b0;
  logic        sensor_pwdn, sensor_rst_n, cfg_valid, rx_enable, streaming, busy, fault;
  logic [7:0]  tbl_idx;
  logic [23:0] tbl_entry;
  logic        cfg_ready   = 1'b1;
  logic [15:0] cfg_addr;
  logic [7:0]  cfg_data;
  logic        cfg_done    = 1'b0;
  logic        resp_err    = 1'b0;
  logic        force_err   = 1'b0;
  logic        cfg_err;
  logic        frame_start = 1'b0;
  logic [1:0]  retry_cnt;
  logic [2:0]  state;

  // bench control (written only by the stimulus block)
  logic ready_en = 1'b1;
  logic frame_en = 1'b0;
  logic err_req  = 1'b0;

  // responder state (written only by the responder)
  int          hold_left = 7;
  logic        err_used  = 1'b0;
  logic        err_this  = 1'b0;
  int          done_cnt  = 0;
  int          fcnt      = 0;
  int          n_acc     = 0;
  int          n_done    = 0;
  int          stall_cyc = 0;
  int          stall_bad = 0;
  logic [23:0] acc_log [0:63];
  logic        acc_s;
  logic [7:0]  idx_s;
  logic [23:0] pay_s;

  int total = 0;
  int bad   = 0;
  int base;
  int rx_cyc;

  logic [23:0] tbl [0:7];
  initial begin
    tbl[0] = {16'h3008, 8'h82};
    tbl[1] = {16'h0100, 8'h01};
    tbl[2] = {16'h3503, 8'h07};
    tbl[3] = {16'hFFFF, 8'h00};
    tbl[4] = '0; tbl[5] = '0; tbl[6] = '0; tbl[7] = '0;
  end

  assign tbl_entry = (tbl_idx < 8'd8) ? tbl[tbl_idx[2:0]] : 24'h000000;
  assign cfg_err   = resp_err | force_err;

  always #10 clk_50m = ~clk_50m;

  mipi_cam_seq #(
    .PWR_WAIT_CYC(10),
    .RST_WAIT_CYC(5),
    .NUM_REGS(64),
    .CFG_TIMEOUT_CYC(20),
    .FRAME_TIMEOUT_CYC(100),
    .MAX_RETRY(3)
  ) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .start(start), .stop(stop),
    .sensor_pwdn(sensor_pwdn), .sensor_rst_n(sensor_rst_n),
    .tbl_idx(tbl_idx), .tbl_entry(tbl_entry),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_done(cfg_done), .cfg_err(cfg_err),
    .rx_enable(rx_enable), .frame_start(frame_start),
    .streaming(streaming), .busy(busy), .fault(fault),
    .retry_cnt(retry_cnt), .state(state)
  );

  // Config engine + frame source: done/err 3 edges after accept, frames every 50 edges.
  always @(posedge clk_50m) begin
    acc_s = cfg_valid && cfg_ready;
    idx_s = tbl_idx;
    pay_s = {cfg_addr, cfg_data};
    if (cfg_valid && !cfg_ready && tbl_idx == 8'd1) begin
      stall_cyc++;
      if (pay_s != tbl[1]) stall_bad++;
    end
    #1;
    cfg_done = 1'b0;
    resp_err = 1'b0;
    if (done_cnt != 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        if (err_this) resp_err = 1'b1;
        else begin
          cfg_done = 1'b1;
          n_done++;
        end
      end
    end
    if (acc_s) begin
      acc_log[n_acc % 64] = pay_s;
      n_acc++;
      done_cnt = 2;
      err_this = err_req && !err_used && (idx_s == 8'd2);
      if (err_this) err_used = 1'b1;
    end
    frame_start = 1'b0;
    if (frame_en) begin
      if (fcnt == 49) begin
        fcnt = 0;
        frame_start = 1'b1;
      end else fcnt++;
    end else fcnt = 0;
    cfg_ready = ready_en && !(cfg_valid && tbl_idx == 8'd1 && hold_left != 0);
    if (cfg_valid && tbl_idx == 8'd1 && hold_left != 0) hold_left--;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_50m);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---- reset state ----
    tick(3);
    chk("rst_state", state, 0);
    chk("rst_pwdn", sensor_pwdn, 1);
    chk("rst_srst", sensor_rst_n, 0);
    chk("rst_outs", {cfg_valid, rx_enable, streaming, busy, fault, retry_cnt, tbl_idx}, 0);
    chk("rst_payload", {cfg_addr, cfg_data}, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_state", state, 0);

    // ---- nominal bring-up, entry 1 stalled 7 cycles by cfg_ready ----
    start = 1'b1;
    tick();
    chk("pwr_state", state, 1);
    chk("pwr_pwdn", sensor_pwdn, 0);
    chk("pwr_busy", busy, 1);
    tick();          // start still high in PWR_UP: ignored
    start = 1'b0;
    tick(8);
    chk("rel_before", sensor_rst_n, 0);
    tick();
    chk("rel_rise", sensor_rst_n, 1);
    chk("rel_state", state, 2);
    tick(5);
    chk("issue_state", state, 3);
    chk("issue_nvalid", cfg_valid, 0);
    tick();
    chk("first_valid", cfg_valid, 1);
    chk("first_payload", {cfg_addr, cfg_data}, tbl[0]);
    for (int i = 0; i < 300 && !rx_enable; i++) tick();
    chk("rx_en", rx_enable, 1);
    chk("rx_state", state, 5);
    chk("rx_after_3done", n_done, 3);
    chk("n_writes", n_acc, 3);
    chk("wr0", acc_log[0], tbl[0]);
    chk("wr1", acc_log[1], tbl[1]);
    chk("wr2", acc_log[2], tbl[2]);
    chk("stall_cycles", stall_cyc, 7);
    chk("stall_stable", stall_bad, 0);
    frame_en = 1'b1;
    for (int i = 0; i < 200 && !streaming; i++) tick();
    chk("stream", streaming, 1);
    chk("stream_state", state, 6);
    chk("stream_busy", busy, 0);
    chk("stream_retry", retry_cnt, 0);

    // ---- frames stop while streaming: timeout 100 cycles after last pulse ----
    tick(150);
    chk("stream_held", state, 6);
    frame_en = 1'b0;
    tick(99);
    chk("wd_before", state, 6);
    tick();
    chk("wd_state", state, 1);
    chk("wd_retry", retry_cnt, 1);
    chk("wd_rx_off", rx_enable, 0);
    chk("wd_pwdn_pulse", sensor_pwdn, 1);
    tick();
    chk("wd_pwdn_low", sensor_pwdn, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop1_state", state, 0);
    chk("stop1_retry", retry_cnt, 0);

    // ---- cfg_err on entry 2 in the first attempt ----
    err_req = 1'b1;
    base = n_acc;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 300 && retry_cnt != 2'd1; i++) tick();
    chk("err_retry", retry_cnt, 1);
    chk("err_pwdn_pulse", sensor_pwdn, 1);
    chk("err_state", state, 1);
    chk("err_idx", tbl_idx, 0);
    chk("err_nvalid", cfg_valid, 0);
    tick();
    chk("err_pwdn_low", sensor_pwdn, 0);
    frame_en = 1'b1;
    for (int i = 0; i < 600 && !streaming; i++) tick();
    chk("err_stream", streaming, 1);
    chk("err_retry_keep", retry_cnt, 1);
    chk("err_nwrites", n_acc - base, 6);
    chk("err_restart_idx0", acc_log[(base + 3) % 64], tbl[0]);
    err_req  = 1'b0;
    frame_en = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // ---- no frames at all: three RX_WAIT timeouts then FAULT ----
    rx_cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 1500 && state != 3'd7; i++) begin
      if (state == 3'd5) rx_cyc++;
      tick();
    end
    chk("flt_state", state, 7);
    chk("flt_rx_cycles", rx_cyc, 300);
    chk("flt_fault", fault, 1);
    chk("flt_retry", retry_cnt, 3);
    chk("flt_pwdn", sensor_pwdn, 1);
    chk("flt_outs", {sensor_rst_n, rx_enable, busy, streaming}, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_state", state, 1);
    chk("restart_fault", fault, 0);
    chk("restart_retry", retry_cnt, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // ---- stop while cfg_valid is pending unaccepted, with a stray cfg_err ----
    ready_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && !cfg_valid; i++) tick();
    chk("pend_valid", cfg_valid, 1);
    base = n_acc;
    stop = 1'b1;
    force_err = 1'b1;
    tick();
    stop = 1'b0;
    force_err = 1'b0;
    ready_en = 1'b1;
    chk("stop2_state", state, 0);
    chk("stop2_valid", cfg_valid, 0);
    chk("stop2_retry", retry_cnt, 0);
    chk("stop2_fault", fault, 0);
    chk("stop2_pwdn", sensor_pwdn, 1);
    chk("stop2_noacc", n_acc - base, 0);

    // ---- async reset in CFG_WAIT ----
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && state != 3'd4; i++) tick();
    chk("cw_state", state, 4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_pwr", {sensor_pwdn, sensor_rst_n}, 2'b10);
    chk("arst_outs", {cfg_valid, rx_enable, streaming, busy, fault, retry_cnt, tbl_idx}, 0);
    chk("arst_payload", {cfg_addr, cfg_data}, 0);
    tick();
    rst_n = 1'b1;
    tick(5);
    chk("arst_idle", state, 0);
    chk("arst_idle_valid", cfg_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
